// File: rtl/mem_if_pkg.sv
// Shared types for the unified memory port: bus width defaults, arbiter FSM states, owner ids.
// No logic, so no latency.
// No flow control of its own.
package mem_if_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, load/store and memory-port signals seen by mem_arbiter.
// Wires only, so no latency.
// valid/ready on every request side; responses are single-cycle pulses with no backpressure.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_if_pkg::DEF_ADDR_W,
    parameter int DATA_W = mem_if_pkg::DEF_DATA_W
);
    logic                  i_valid;
    logic                  i_ready;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_rvalid;
    logic [DATA_W-1:0]     i_rdata;

    logic                  d_valid;
    logic                  d_ready;
    logic [ADDR_W-1:0]     d_addr;
    logic                  d_wen;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wmask;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_wen;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    // arbiter side
    modport master (
        input  i_valid, i_addr,
        output i_ready, i_rvalid, i_rdata,
        input  d_valid, d_addr, d_wen, d_wdata, d_wmask,
        output d_ready, d_rvalid, d_rdata,
        output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    // core and memory side
    modport slave (
        output i_valid, i_addr,
        input  i_ready, i_rvalid, i_rdata,
        output d_valid, d_addr, d_wen, d_wdata, d_wmask,
        input  d_ready, d_rvalid, d_rdata,
        input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Chooses the owner of the next memory command: a held lock wins, then D unless I is starving, then I.
// Selection is combinational; lock and starve count update on the handshake edge.
// A command stalled by mem_ready=0 locks its owner so the memory sees stable fields until accepted.
module mem_arb_pick
    import mem_if_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   idle,
    input  logic   i_valid,
    input  logic   d_valid,
    input  logic   mem_ready,
    output logic   pick_vld,
    output owner_t owner
);

    localparam int               CNT_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic             lock;
    owner_t           lock_owner;
    logic [CNT_W-1:0] cnt;
    logic             starve;
    logic             hs;

    always_comb begin
        starve   = (STARVE_LIMIT != 0) && i_valid && (cnt == CNT_MAX);
        owner    = OWN_I;
        pick_vld = 1'b0;
        if (idle) begin
            if (lock) begin
                owner    = lock_owner;
                pick_vld = (lock_owner == OWN_D) ? d_valid : i_valid;
            end else if (d_valid && !starve) begin
                owner    = OWN_D;
                pick_vld = 1'b1;
            end else if (i_valid) begin
                pick_vld = 1'b1;
            end
        end
        hs = pick_vld && mem_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock       <= 1'b0;
            lock_owner <= OWN_I;
            cnt        <= '0;
        end else begin
            if (hs) begin
                lock <= 1'b0;
            end else if (pick_vld) begin
                lock       <= 1'b1;
                lock_owner <= owner;
            end
            // count D wins only while I is actually waiting; saturates at the limit
            if ((hs && owner == OWN_I) || (idle && !i_valid)) begin
                cnt <= '0;
            end else if (hs && i_valid && cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D), one transaction outstanding at a time.
// Command is offered combinationally from IDLE; response passes through in the same cycle as mem_rvalid.
// Requesters stall on ready; the memory stalls commands with mem_ready; back-to-back is one txn per 2 cycles.
module mem_arbiter
    import mem_if_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       idle;
    logic       pick_vld;
    owner_t     owner;

    assign idle = (state_q == ST_IDLE) && rst_n;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk       (clk),
        .rst_n     (rst_n),
        .idle      (idle),
        .i_valid   (bus.i_valid),
        .d_valid   (bus.d_valid),
        .mem_ready (bus.mem_ready),
        .pick_vld  (pick_vld),
        .owner     (owner)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wen   = 1'b0;
        bus.mem_wdata = '0;
        bus.mem_wmask = '0;
        bus.i_ready   = 1'b0;
        bus.d_ready   = 1'b0;
        bus.i_rvalid  = 1'b0;
        bus.i_rdata   = '0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = '0;
        // outputs are held quiet for the whole time rst_n is low, not just after the first edge
        if (rst_n) begin
            unique case (state_q)
                ST_IDLE: begin
                    bus.mem_valid = pick_vld;
                    if (owner == OWN_D) begin
                        bus.mem_addr  = bus.d_addr;
                        bus.mem_wen   = bus.d_wen;
                        bus.mem_wdata = bus.d_wen ? bus.d_wdata : '0;
                        bus.mem_wmask = bus.d_wen ? bus.d_wmask : '0;
                        bus.d_ready   = pick_vld && bus.mem_ready;
                    end else begin
                        bus.mem_addr  = bus.i_addr;
                        bus.i_ready   = pick_vld && bus.mem_ready;
                    end
                    if (pick_vld && bus.mem_ready) begin
                        state_d = (owner == OWN_D) ? ST_BUSY_D : ST_BUSY_I;
                    end
                end
                ST_BUSY_I: begin
                    if (bus.mem_rvalid) begin
                        bus.i_rvalid = 1'b1;
                        bus.i_rdata  = bus.mem_rdata;
                        state_d      = ST_IDLE;
                    end
                end
                ST_BUSY_D: begin
                    if (bus.mem_rvalid) begin
                        bus.d_rvalid = 1'b1;
                        bus.d_rdata  = bus.mem_rdata;
                        state_d      = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;
    import mem_if_pkg::*;

    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));

    int total = 0;
    int bad   = 0;

    // memory contents seen by the DUT, and the bench's own view of what they should be
    logic [31:0] mem_arr [256];
    logic [31:0] ref_mem [256];

    // reference model: outstanding owner, stall lock, consecutive D wins while I waits
    bit          m_out, m_out_d, m_lock, m_lock_d;
    int          m_streak;
    logic [31:0] m_exp;

    int          rdy_mode, lat_min, lat_max;
    bit          stray_en;
    int          mp_cnt;
    logic [31:0] mp_data;
    bit          b0_pend;

    bit          o_i_hs, o_d_hs, o_i_rv, o_d_rv, o0_i_hs, o0_d_hs;
    logic [31:0] o_i_rd, o_d_rd, o_addr;

    int          ni, nd, n_gr, i_acc, d_acc, i_resp, d_resp;
    logic [15:0] seqv;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // One clock: drive memory side, check DUT against the model, advance model and memory.
    task automatic cycle();
        bit          gd, offer, hs, erv_i, erv_d;
        logic [31:0] a;
        logic [7:0]  idx;
        case (rdy_mode)
            0:       bus.mem_ready = ($urandom_range(0, 3) != 0);
            1:       bus.mem_ready = 1'b1;
            default: bus.mem_ready = 1'b0;
        endcase
        if (mp_cnt == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mp_data;
        end else if (stray_en && mp_cnt < 0 && !m_out && $urandom_range(0, 7) == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = $urandom;
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
        end
        bus0.mem_ready  = 1'b1;
        bus0.mem_rvalid = b0_pend;
        bus0.mem_rdata  = 32'h0;
        #1;
        gd = 1'b0;
        offer = 1'b0;
        if (rst_n && !m_out) begin
            if (m_lock) begin
                gd    = m_lock_d;
                offer = gd ? bus.d_valid : bus.i_valid;
            end else if (bus.d_valid && !(bus.i_valid && LIM != 0 && m_streak == LIM)) begin
                gd    = 1'b1;
                offer = 1'b1;
            end else if (bus.i_valid) begin
                offer = 1'b1;
            end
        end
        hs    = offer && bus.mem_ready;
        erv_i = rst_n && m_out && !m_out_d && bus.mem_rvalid;
        erv_d = rst_n && m_out && m_out_d && bus.mem_rvalid;
        chk("mem_valid", bus.mem_valid, offer);
        chk("i_ready", bus.i_ready, hs && !gd);
        chk("d_ready", bus.d_ready, hs && gd);
        chk("i_rvalid", bus.i_rvalid, erv_i);
        chk("d_rvalid", bus.d_rvalid, erv_d);
        chk("i_rdata", bus.i_rdata, erv_i ? m_exp : 32'h0);
        chk("d_rdata", bus.d_rdata, erv_d ? m_exp : 32'h0);
        if (offer) begin
            chk("mem_addr", bus.mem_addr, gd ? bus.d_addr : bus.i_addr);
            chk("mem_wen", bus.mem_wen, gd && bus.d_wen);
            chk("mem_wmask", bus.mem_wmask, (gd && bus.d_wen) ? bus.d_wmask : 4'h0);
            if (!gd || bus.d_wen) chk("mem_wdata", bus.mem_wdata, gd ? bus.d_wdata : 32'h0);
        end
        o_i_hs  = bus.i_valid && bus.i_ready;
        o_d_hs  = bus.d_valid && bus.d_ready;
        o_i_rv  = bus.i_rvalid;
        o_d_rv  = bus.d_rvalid;
        o_i_rd  = bus.i_rdata;
        o_d_rd  = bus.d_rdata;
        o_addr  = bus.mem_addr;
        o0_i_hs = bus0.i_valid && bus0.i_ready;
        o0_d_hs = bus0.d_valid && bus0.d_ready;
        if (!rst_n) begin
            m_out    = 1'b0;
            m_lock   = 1'b0;
            m_streak = 0;
        end else if (m_out) begin
            if (bus.mem_rvalid) m_out = 1'b0;
        end else begin
            if (hs) begin
                m_out   = 1'b1;
                m_out_d = gd;
                m_lock  = 1'b0;
                a       = gd ? bus.d_addr : bus.i_addr;
                idx     = a[9:2];
                m_exp   = (gd && bus.d_wen) ? 32'h0 : ref_mem[idx];
                if (gd && bus.d_wen) ref_mem[idx] = merge(ref_mem[idx], bus.d_wdata, bus.d_wmask);
            end else if (offer) begin
                m_lock   = 1'b1;
                m_lock_d = gd;
            end
            if ((hs && !gd) || !bus.i_valid) m_streak = 0;
            else if (hs && gd && m_streak < LIM) m_streak++;
        end
        if (!rst_n) begin
            mp_cnt = -1;
        end else begin
            if (mp_cnt == 0) mp_cnt = -1;
            else if (mp_cnt > 0) mp_cnt--;
            if (bus.mem_valid && bus.mem_ready) begin
                a      = bus.mem_addr;
                idx    = a[9:2];
                mp_cnt = $urandom_range(lat_min, lat_max);
                if (bus.mem_wen) begin
                    mem_arr[idx] = merge(mem_arr[idx], bus.mem_wdata, bus.mem_wmask);
                    mp_data      = 32'h0;
                end else begin
                    mp_data = mem_arr[idx];
                end
            end
        end
        b0_pend = rst_n && bus0.mem_valid && bus0.mem_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_valid = 0;  bus.i_addr = 0;  bus.d_valid = 0;  bus.d_addr = 0;
        bus.d_wen = 0;    bus.d_wdata = 0; bus.d_wmask = 0;
        bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        bus0.i_valid = 0; bus0.i_addr = 0; bus0.d_valid = 0; bus0.d_addr = 0;
        bus0.d_wen = 0;   bus0.d_wdata = 0; bus0.d_wmask = 0;
        bus0.mem_ready = 0; bus0.mem_rvalid = 0; bus0.mem_rdata = 0;
        m_out = 0; m_out_d = 0; m_lock = 0; m_lock_d = 0; m_streak = 0; m_exp = 0;
        rdy_mode = 1; lat_min = 0; lat_max = 0; stray_en = 0;
        mp_cnt = -1; mp_data = 0; b0_pend = 0;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[0] = 32'h1234_5678; ref_mem[0] = 32'h1234_5678;
        mem_arr[2] = 32'hCAFE_F00D; ref_mem[2] = 32'hCAFE_F00D;
        @(posedge clk);
        #1;

        // reset: outputs stay 0 even with requests pending
        cycle();
        bus.i_valid = 1; bus.d_valid = 1;
        cycle();
        chk("rst_mem_valid", bus.mem_valid, 1'b0);
        bus.i_valid = 0; bus.d_valid = 0;
        rst_n = 1'b1;
        cycle();

        // I only, addr 0, one-cycle memory
        bus.i_valid = 1; bus.i_addr = 32'h0;
        cycle();
        chk("a_i_acc", o_i_hs, 1'b1);
        bus.i_valid = 0;
        cycle();
        chk("a_i_rv", o_i_rv, 1'b1);
        chk("a_i_data", o_i_rd, 32'h1234_5678);
        chk("a_d_rv", o_d_rv, 1'b0);

        // simultaneous I and D: store goes first, I reads it back
        bus.i_valid = 1; bus.i_addr = 32'h100;
        bus.d_valid = 1; bus.d_addr = 32'h100; bus.d_wen = 1;
        bus.d_wdata = 32'hDEAD_BEEF; bus.d_wmask = 4'hF;
        cycle();
        chk("b_d_first", o_d_hs, 1'b1);
        chk("b_i_wait", o_i_hs, 1'b0);
        bus.d_valid = 0; bus.d_wen = 0;
        cycle();
        chk("b_d_ack", o_d_rv, 1'b1);
        chk("b_d_ackdata", o_d_rd, 32'h0);
        cycle();
        chk("b_i_next", o_i_hs, 1'b1);
        bus.i_valid = 0;
        cycle();
        chk("b_rdback_v", o_i_rv, 1'b1);
        chk("b_rdback", o_i_rd, 32'hDEAD_BEEF);

        // starvation limit 4: D,D,D,D then I, then D again
        bus.i_valid = 1; bus.i_addr = 32'h4; bus.d_valid = 1; bus.d_wen = 0;
        seqv = 0; n_gr = 0;
        for (int k = 0; k < 12; k++) begin
            bus.d_addr = 32'h200 + 32'(k * 4);
            cycle();
            if (o_d_hs || o_i_hs) begin
                seqv = {seqv[14:0], o_d_hs};
                n_gr++;
            end
        end
        chk("c_grants", n_gr, 6);
        chk("c_order", seqv, 16'b11_1101);
        bus.i_valid = 0; bus.d_valid = 0;
        cycle();

        // strict D priority on the limit-0 instance
        bus0.i_valid = 1; bus0.i_addr = 32'h10; bus0.d_valid = 1; bus0.d_addr = 32'h20;
        ni = 0; nd = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            ni += int'(o0_i_hs);
            nd += int'(o0_d_hs);
        end
        chk("d0_no_i", ni, 0);
        chk("d0_d_grants", nd, 5);
        bus0.d_valid = 0; ni = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (o0_i_hs) begin
                ni++;
                bus0.i_valid = 0;
            end
        end
        chk("d0_i_after", ni, 1);

        // memory stall keeps I locked in while D shows up
        rdy_mode = 2;
        bus.i_valid = 1; bus.i_addr = 32'h40;
        cycle();
        chk("e_addr0", o_addr, 32'h40);
        chk("e_hold0", o_i_hs, 1'b0);
        bus.d_valid = 1; bus.d_addr = 32'h80; bus.d_wen = 0;
        cycle();
        chk("e_addr1", o_addr, 32'h40);
        cycle();
        chk("e_addr2", o_addr, 32'h40);
        rdy_mode = 1;
        cycle();
        chk("e_i_acc", o_i_hs, 1'b1);
        chk("e_d_wait", o_d_hs, 1'b0);
        bus.i_valid = 0;
        cycle();
        cycle();
        chk("e_d_acc", o_d_hs, 1'b1);
        bus.d_valid = 0;
        cycle();

        // reset while D outstanding; a late response afterwards must be dropped
        lat_min = 20; lat_max = 20;
        bus.d_valid = 1; bus.d_addr = 32'h30; bus.d_wen = 0;
        cycle();
        chk("f_d_acc", o_d_hs, 1'b1);
        bus.d_valid = 0;
        cycle();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        lat_min = 0; lat_max = 0;
        mp_cnt = 0; mp_data = 32'hBAD0_BAD0;
        cycle();
        chk("f_no_d_rv", o_d_rv, 1'b0);
        chk("f_no_i_rv", o_i_rv, 1'b0);
        bus.i_valid = 1; bus.i_addr = 32'h8;
        cycle();
        chk("f_i_acc", o_i_hs, 1'b1);
        bus.i_valid = 0;
        cycle();
        chk("f_i_rv", o_i_rv, 1'b1);
        chk("f_i_data", o_i_rd, 32'hCAFE_F00D);

        // random traffic with stalls, variable latency and stray responses
        rdy_mode = 0; lat_min = 0; lat_max = 2; stray_en = 1;
        i_acc = 0; d_acc = 0; i_resp = 0; d_resp = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!bus.i_valid && $urandom_range(0, 1) == 1) begin
                bus.i_valid = 1;
                bus.i_addr  = {22'h0, 8'($urandom), 2'b00};
            end
            if (!bus.d_valid && $urandom_range(0, 1) == 1) begin
                bus.d_valid = 1;
                bus.d_addr  = {22'h0, 8'($urandom), 2'b00};
                bus.d_wen   = 1'($urandom);
                bus.d_wdata = $urandom;
                bus.d_wmask = 4'($urandom);
            end
            cycle();
            if (o_i_hs) begin i_acc++; bus.i_valid = 0; end
            if (o_d_hs) begin d_acc++; bus.d_valid = 0; end
            if (o_i_rv) i_resp++;
            if (o_d_rv) d_resp++;
        end
        bus.i_valid = 0; bus.d_valid = 0; stray_en = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (o_i_rv) i_resp++;
            if (o_d_rv) d_resp++;
        end
        chk("sb_i_count", i_resp, i_acc);
        chk("sb_d_count", d_resp, d_acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
